// File: rtl/pc_predict_unit.sv
// pc_predict_unit: fetch PC register with an optional branch target buffer.
// Build macro PC_PREDICT_BTB_EN adds a direct-mapped BTB with 2-bit
// saturating direction counters. Without it, the next PC is chosen as
// redirect > stall (hold) > sequential (+4), and the upd_* ports are ignored.
module pc_predict_unit #(
  parameter int                WORD_W    = 32,
  parameter int                BTB_DEPTH = 16,
  parameter logic [WORD_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              upd_valid,
  input  logic [WORD_W-1:0] upd_pc,
  input  logic [WORD_W-1:0] upd_target,
  input  logic              upd_taken,
  output logic [WORD_W-1:0] current_pc,
  output logic              pred_taken
);

  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] w_pc_inc;
  logic [WORD_W-1:0] w_next_pc;
  logic              w_pred_taken;
  logic [WORD_W-1:0] w_pred_target;

  // Sequential fetch address; the addition wraps naturally at 2^WORD_W.
  assign w_pc_inc = r_pc + WORD_W'(4);

`ifdef PC_PREDICT_BTB_EN
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  // Valid bits and counters carry reset state; tags and targets do not,
  // since a cleared valid bit makes their contents irrelevant.
  logic [BTB_DEPTH-1:0] r_valid;
  logic [1:0]           r_ctr    [BTB_DEPTH];
  logic [TAG_W-1:0]     r_tag    [BTB_DEPTH];
  logic [WORD_W-1:0]    r_target [BTB_DEPTH];

  logic [IDX_W-1:0] w_rd_idx;
  logic [TAG_W-1:0] w_rd_tag;
  logic             w_rd_hit;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic [1:0]       w_ctr_cur;
  logic [1:0]       w_ctr_new;
  logic             w_unused;

  // Lookup for the current fetch PC; the byte offset bits take no part.
  assign w_rd_idx      = r_pc[IDX_W+1:2];
  assign w_rd_tag      = r_pc[WORD_W-1:IDX_W+2];
  assign w_rd_hit      = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign w_pred_taken  = w_rd_hit && r_ctr[w_rd_idx][1];
  assign w_pred_target = r_target[w_rd_idx];

  // Lookup for the resolved branch being written back.
  assign w_upd_idx = upd_pc[IDX_W+1:2];
  assign w_upd_tag = upd_pc[WORD_W-1:IDX_W+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_ctr_cur = r_ctr[w_upd_idx];
  assign w_unused  = ^upd_pc[1:0];

  // Saturating counter step toward the resolved direction.
  always_comb begin
    // NOTE: assigning a default first means every path drives w_ctr_new, so no latch is inferred.
    w_ctr_new = w_ctr_cur;
    if (upd_taken) begin
      if (w_ctr_cur != 2'b11) w_ctr_new = w_ctr_cur + 2'b01;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_new = w_ctr_cur - 2'b01;
    end
  end

  // Valid bits and counters: reset clears them and abandons a coinciding update.
  always_ff @(posedge clk) begin
    // NOTE: only the state that decides a hit is reset; the large tag/target arrays are left unreset.
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) r_ctr[i] <= 2'b01;
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        r_ctr[w_upd_idx] <= w_ctr_new;
      end else if (upd_taken) begin
        r_valid[w_upd_idx] <= 1'b1;
        r_ctr[w_upd_idx]   <= 2'b10;
      end
    end
  end

  // Tag and target payload, written on any taken update (hit refresh or allocation).
  always_ff @(posedge clk) begin
    if (!reset && upd_valid && upd_taken) begin
      r_tag[w_upd_idx]    <= w_upd_tag;
      r_target[w_upd_idx] <= upd_target;
    end
  end
`else
  logic w_unused;

  assign w_pred_taken  = 1'b0;
  assign w_pred_target = '0;
  assign w_unused      = ^{upd_valid, upd_pc, upd_target, upd_taken};
`endif

  // Next-PC priority: redirect, then stall hold, then predicted target, then +4.
  always_comb begin
    w_next_pc = w_pc_inc;
    if (redirect_valid)    w_next_pc = redirect_pc;
    else if (stall)        w_next_pc = r_pc;
    else if (w_pred_taken) w_next_pc = w_pred_target;
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    if (reset) r_pc <= RESET_PC;
    else       r_pc <= w_next_pc;
  end

  assign current_pc = r_pc;
  assign pred_taken = w_pred_taken;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Self-checking bench for pc_predict_unit. A behavioural reference model
// predicts each next PC, which is pushed to a scoreboard queue when the
// cycle's stimulus is driven and compared after the clock edge. The model
// follows the same PC_PREDICT_BTB_EN build option as the design.
module tb_pc_predict_unit;

  localparam int          WORD_W    = 32;
  localparam int          BTB_DEPTH = 16;
  localparam logic [31:0] RESET_PC  = 32'h100;
  localparam int          IDX_W     = $clog2(BTB_DEPTH);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [31:0] upd_target = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] current_pc;
  logic        pred_taken;

  pc_predict_unit #(
    .WORD_W   (WORD_W),
    .BTB_DEPTH(BTB_DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_target    (upd_target),
    .upd_taken     (upd_taken),
    .current_pc    (current_pc),
    .pred_taken    (pred_taken)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    string       tag;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state.
  logic        m_live = 1'b0;
  logic [31:0] m_pc;
  logic        m_valid  [BTB_DEPTH];
  logic [31:0] m_tag    [BTB_DEPTH];
  logic [31:0] m_target [BTB_DEPTH];
  logic [1:0]  m_ctr    [BTB_DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % BTB_DEPTH);
  endfunction

  function automatic logic m_hit(input logic [31:0] pc);
`ifdef PC_PREDICT_BTB_EN
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> (IDX_W + 2)));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_pred(input logic [31:0] pc);
    return m_hit(pc) && m_ctr[m_idx(pc)][1];
  endfunction

  // One clock cycle: drive, predict, push; then after the edge pop and compare.
  task automatic step(input string tag, input logic rst, input logic st,
                      input logic rv, input logic [31:0] rpc,
                      input logic uv, input logic [31:0] upc,
                      input logic [31:0] utgt, input logic ut);
    logic  p;
    int    i;
    exp_t  e;
    @(negedge clk);
    reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc;
    upd_valid = uv; upd_pc = upd_pc; upd_pc = upc; upd_target = utgt; upd_taken = ut;
    #1;
    if (rst) begin
      m_pc = RESET_PC;
      for (int k = 0; k < BTB_DEPTH; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 2'b01;
      end
      m_live = 1'b1;
    end else if (m_live) begin
      p = m_pred(m_pc);
      check({tag, "_pred"}, 64'(pred_taken), 64'(p));
      if (rv)      m_pc = rpc;
      else if (st) m_pc = m_pc;
      else if (p)  m_pc = m_target[m_idx(m_pc)];
      else         m_pc = m_pc + 32'd4;
`ifdef PC_PREDICT_BTB_EN
      if (uv) begin
        i = m_idx(upc);
        if (m_hit(upc)) begin
          if (ut && m_ctr[i] != 2'b11) m_ctr[i] = m_ctr[i] + 2'b01;
          if (!ut && m_ctr[i] != 2'b00) m_ctr[i] = m_ctr[i] - 2'b01;
          if (ut) m_target[i] = utgt;
        end else if (ut) begin
          m_valid[i]  = 1'b1;
          m_tag[i]    = upc >> (IDX_W + 2);
          m_target[i] = utgt;
          m_ctr[i]    = 2'b10;
        end
      end
`endif
    end
    if (m_live) sb_q.push_back('{pc: m_pc, tag: tag});
    @(posedge clk);
    #1;
    if (m_live) begin
      if (sb_q.size() == 0) begin
        check({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check({e.tag, "_pc"}, 64'(current_pc), 64'(e.pc));
      end
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic redir(input string tag, input logic [31:0] pc);
    step(tag, 1'b0, 1'b0, 1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic upd(input string tag, input logic [31:0] pc,
                     input logic [31:0] tgt, input logic taken);
    step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, pc, tgt, taken);
  endtask

  initial begin
    // Reset for two cycles, then three free-running cycles: 0x104, 0x108, 0x10C.
    step("rst0", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    step("rst1", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("reset_pc", 64'(current_pc), 64'h100);
    check("reset_pred", 64'(pred_taken), 64'd0);
    idle("seq0");
    idle("seq1");
    idle("seq2");

    // Allocate 0x108 -> 0x200 taken, revisit: predicted taken to 0x200.
    upd("alloc108", 32'h108, 32'h200, 1'b1);
    redir("go108a", 32'h108);
    idle("hit108");

    // Two not-taken updates (10 -> 01 -> 00): no longer predicted.
    upd("nt1", 32'h108, 32'h0, 1'b0);
    upd("nt2", 32'h108, 32'h0, 1'b0);
    redir("go108b", 32'h108);
    idle("miss108");
    // Taken update 00 -> 01: still not predicted.
    upd("t01", 32'h108, 32'h200, 1'b1);
    redir("go108c", 32'h108);
    // While at 0x108 (counter 01) train taken; same-cycle lookup sees old 01.
    upd("bypass", 32'h108, 32'h280, 1'b1);
    redir("go108d", 32'h108);
    idle("hit108b");

    // Redirect wins over stall; stall alone holds the PC.
    step("stall_redir", 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0);
    step("stall_hold0", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    step("stall_hold1", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Same index, new tag: 0x048 replaces 0x008 with counter 10.
    upd("alloc008", 32'h008, 32'h300, 1'b1);
    upd("alloc048", 32'h048, 32'h400, 1'b1);
    redir("go008", 32'h008);
    idle("miss008");
    redir("go048", 32'h048);
    idle("hit048");
    upd("nt048", 32'h048, 32'h0, 1'b0);
    redir("go048b", 32'h048);
    idle("weak048");

    // Sequential wrap at the top of the address space.
    redir("go_top", 32'hFFFF_FFFC);
    idle("wrap");

    // Reset beats redirect and a coinciding allocation.
    upd("alloc048c", 32'h048, 32'h500, 1'b1);
    step("rst_prio", 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h040, 32'h600, 1'b1);
    check("rst_prio_pc", 64'(current_pc), 64'h100);
    check("rst_prio_pred", 64'(pred_taken), 64'd0);
    redir("go040", 32'h040);
    idle("aband040");
    redir("go048c", 32'h048);
    idle("clr048");

    // Random mix over a small address window so entries alias and retrain.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [31:0] t;
      a = 32'h100 + {$urandom_range(0, 31), 2'b00};
      t = 32'h100 + {$urandom_range(0, 31), 2'b00};
      step("rnd", 1'b0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), a,
           ($urandom_range(0, 1) == 1), 32'h100 + {$urandom_range(0, 31), 2'b00},
           t, ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_predict_unit.md
PC_PREDICT_UNIT -- requirements
Module: pc_predict_unit

Interface
REQ-001 SHALL provide parameter WORD_W, default 32, PC and target width.
REQ-002 SHALL provide parameter BTB_DEPTH, default 16, BTB entry count; power of two, 2 to 256.
REQ-003 SHALL provide parameter RESET_PC, default 0, value loaded into current_pc on reset.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  holds current_pc when no redirect is present.
REQ-007 SHALL have port redirect_valid  input  1  forces next PC to redirect_pc.
REQ-008 SHALL have port redirect_pc  input  WORD_W  redirect target.
REQ-009 SHALL have port upd_valid  input  1  resolved-branch update strobe.
REQ-010 SHALL have port upd_pc  input  WORD_W  PC of the resolved branch.
REQ-011 SHALL have port upd_target  input  WORD_W  resolved branch target.
REQ-012 SHALL have port upd_taken  input  1  resolved branch direction.
REQ-013 SHALL have port current_pc  output  WORD_W  registered fetch PC.
REQ-014 SHALL have port pred_taken  output  1  combinational: current_pc predicted taken.

Function
REQ-015 SHALL use index = pc[IDX_W+1:2] with IDX_W = log2(BTB_DEPTH), and tag = pc[WORD_W-1:IDX_W+2]; pc[1:0] ignored.
REQ-016 SHALL give each entry a valid bit, a tag, a WORD_W target and a 2-bit counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-017 SHALL define hit = entry valid and tag equal; pred_taken = hit AND counter[1].
REQ-018 SHALL select next PC by priority: redirect_valid -> redirect_pc; else stall -> hold; else pred_taken -> entry target; else current_pc + 4.
REQ-019 SHALL apply redirect even while stall = 1.
REQ-020 SHALL compute current_pc + 4 modulo 2^WORD_W (wrap, no flag).
REQ-021 SHALL, on upd_valid with hit on upd_pc, increment the counter saturating at 11 if upd_taken, else decrement it saturating at 00.
REQ-022 SHALL, on upd_valid with hit and upd_taken, write upd_target into the entry.
REQ-023 SHALL, on upd_valid, miss and upd_taken, allocate the entry: valid=1, new tag, target=upd_target, counter=10, overwriting any previous occupant.
REQ-024 SHALL, on upd_valid, miss and not upd_taken, leave the BTB unchanged.
REQ-025 SHALL make BTB writes visible from the next cycle; a same-cycle lookup of the updated index SHALL see old contents (no bypass).
REQ-026 SHALL perform updates independently of stall and redirect_valid.
REQ-027 SHALL reach next PC in one cycle: the selected value appears on current_pc after the next rising edge.

Reset
REQ-028 SHALL, on reset, set current_pc = RESET_PC, clear every valid bit and set every counter to 01.
REQ-029 SHALL give reset priority over redirect, stall and update in the same cycle; pred_taken = 0 in the first cycle after reset.
REQ-030 SHALL abandon an in-flight update coinciding with reset.

Configuration
REQ-031 SHALL use macro PC_PREDICT_BTB_EN: when defined, the BTB and REQ-015..REQ-026 prediction are built.
REQ-032 SHALL, without PC_PREDICT_BTB_EN, contain no BTB storage, tie pred_taken to 0, ignore upd_* ports, and select next PC as redirect > stall > current_pc + 4.

Verification
REQ-033 SHALL cover: reset with RESET_PC=0x100, no stimulus 3 cycles -> current_pc 0x100, 0x104, 0x108; pred_taken 0.
REQ-034 SHALL cover: update upd_pc=0x108, upd_target=0x200, taken; PC later reaches 0x108 -> pred_taken 1, next current_pc 0x200.
REQ-035 SHALL cover: two not-taken updates on the 0x108 entry (10 -> 01 -> 00) -> pred_taken 0 at 0x108, next 0x10C; taken update -> 01, still not predicted.
REQ-036 SHALL cover: stall=1 and redirect_valid=1, redirect_pc=0x40 in one cycle -> current_pc 0x40 next cycle; stall alone -> PC held.
REQ-037 SHALL cover: WORD_W=32, current_pc 0xFFFFFFFC, no hit -> next current_pc 0x00000000.
REQ-038 SHALL cover: BTB_DEPTH=16, allocate at 0x008 then taken update at 0x048 (same index, new tag) -> 0x008 misses, 0x048 hits with counter 10.
